// File: rtl/uart_pkg.sv
// Shared types and sizing helpers for the UART transmit/receive blocks.
// No logic and no latency of its own.
// No flow control of its own.
package uart_pkg;

  // Frame sequencing states shared by transmitter and receiver
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_t;

  // Clock cycles per bit; callers keep the result >= 2
  function automatic int bps_cnt(input int clk_freq, input int uart_bps);
    return clk_freq / uart_bps;
  endfunction

  // Counter width able to hold 0..n-1, never narrower than one bit
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Baud counter: counts 0..BPS_CNT-1 while enabled and flags the last cycle of each bit.
// Latency: bit_end is asserted in the cycle the count reaches BPS_CNT-1.
// Backpressure: none; clr has priority over en and holds the count at zero.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int BPS_CNT = 434,
  parameter int CNT_W   = cnt_width(BPS_CNT)
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic clr,
  input  logic en,
  output logic bit_end
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BPS_CNT - 1);

  logic [CNT_W-1:0] baud_cnt;

  // Last cycle of the current bit; only meaningful while counting
  assign bit_end = en && (baud_cnt == CNT_MAX);

  // Free-running bit-time counter, wraps at each bit boundary
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      baud_cnt <= '0;
    end else if (clr) begin
      baud_cnt <= '0;
    end else if (en) begin
      baud_cnt <= bit_end ? '0 : baud_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_send.sv
// UART transmitter: start bit, DATAWIDTH data bits LSB first, optional parity, stop bit(s).
// Latency: uart_txd falls one cycle after a send_en rise is sampled; frame lasts BPS_CNT*(1+DATAWIDTH+PARITY_EN+STOP_BITS).
// Backpressure: tx_busy high for the whole frame; send_en edges seen while busy are dropped, not queued.
module uart_send
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int UART_BPS   = 115200,
  parameter int DATAWIDTH  = 16,
  parameter bit PARITY_EN  = 1'b0,
  parameter bit PARITY_ODD = 1'b0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic                 send_en,
  input  logic [DATAWIDTH-1:0] send_data,
  output logic                 tx_busy,
  output logic                 tx_done,
  output logic                 uart_txd
);

  localparam int              BPS_CNT   = bps_cnt(CLK_FREQ, UART_BPS);
  localparam int              IDX_W     = cnt_width(DATAWIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATAWIDTH - 1);
  localparam logic            STOP_LAST = (STOP_BITS == 2) ? 1'b1 : 1'b0;

  uart_state_t          state;
  uart_state_t          state_nxt;
  logic                 en_d0;
  logic                 start;
  logic                 bit_end;
  logic [DATAWIDTH-1:0] shift_reg;
  logic                 parity_bit;
  logic [IDX_W-1:0]     bit_idx;
  logic                 stop_idx;
  logic                 txd_nxt;
  logic                 busy_nxt;
  logic                 done_nxt;

  // Only a fresh rising edge in IDLE starts a frame; held levels never retrigger
  assign start = send_en && !en_d0 && (state == IDLE);

  uart_baud_gen #(
    .BPS_CNT (BPS_CNT)
  ) u_baud_gen (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .clr     (state == IDLE),
    .en      (tx_busy),
    .bit_end (bit_end)
  );

  // Request edge detector history
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      en_d0 <= 1'b0;
    end else begin
      en_d0 <= send_en;
    end
  end

  // State and registered line outputs
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state    <= IDLE;
      uart_txd <= 1'b1;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
    end else begin
      state    <= state_nxt;
      uart_txd <= txd_nxt;
      tx_busy  <= busy_nxt;
      tx_done  <= done_nxt;
    end
  end

  // Next state and next line level, chosen at each bit boundary
  always_comb begin
    state_nxt = state;
    txd_nxt   = uart_txd;
    busy_nxt  = tx_busy;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        txd_nxt  = 1'b1;
        busy_nxt = 1'b0;
        if (start) begin
          state_nxt = START;
          txd_nxt   = 1'b0;
          busy_nxt  = 1'b1;
        end
      end
      START: begin
        if (bit_end) begin
          state_nxt = DATA;
          txd_nxt   = shift_reg[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_idx == LAST_IDX) begin
            if (PARITY_EN) begin
              state_nxt = PARITY;
              txd_nxt   = parity_bit;
            end else begin
              state_nxt = STOP;
              txd_nxt   = 1'b1;
            end
          end else begin
            // Next bit is what sits in position 1 before this edge's shift
            txd_nxt = shift_reg[1];
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_nxt = STOP;
          txd_nxt   = 1'b1;
        end
      end
      STOP: begin
        txd_nxt = 1'b1;
        if (bit_end && (stop_idx == STOP_LAST)) begin
          state_nxt = IDLE;
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        txd_nxt   = 1'b1;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  // Word capture, parity, data shifting and bit/stop counting
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      shift_reg  <= '0;
      parity_bit <= 1'b0;
      bit_idx    <= '0;
      stop_idx   <= 1'b0;
    end else if (start) begin
      shift_reg  <= send_data;
      parity_bit <= (^send_data) ^ PARITY_ODD;
      bit_idx    <= '0;
      stop_idx   <= 1'b0;
    end else if (bit_end) begin
      if (state == DATA) begin
        shift_reg <= {1'b0, shift_reg[DATAWIDTH-1:1]};
        bit_idx   <= bit_idx + IDX_W'(1);
      end
      if (state == STOP) begin
        stop_idx <= ~stop_idx;
      end
    end
  end

endmodule

// File: tb/tb_uart_send.sv
// Bench for uart_send: four instances (plain, even parity, odd parity, two stop bits).
// A queue-based frame model predicts txd/busy/done every cycle; directed tests pin literal values.
// All instances run at BPS_CNT = 10.
module tb_uart_send;

  localparam int BPS      = 10;
  localparam int M_HOLD   = 1;
  localparam int M_CHG    = 2;
  localparam int M_REEDGE = 4;
  localparam int M_RST    = 8;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic [3:0]  send_en = 4'b0;
  logic [15:0] send_data [4];
  logic [3:0]  busy;
  logic [3:0]  done;
  logic [3:0]  txd;

  int checks = 0;
  int errors = 0;
  bit cmp_on = 1'b0;

  int cfg_par_en  [4] = '{0, 1, 1, 0};
  int cfg_par_odd [4] = '{0, 0, 1, 0};
  int cfg_stops   [4] = '{1, 1, 1, 2};

  // Hand-derived bit sequence for 16'hA5C3: start, data LSB first, stop
  logic exp_basic [18] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1,
                           1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

  // Model state: per instance, a queue of {txd, busy, done} per cycle
  logic [2:0] mq [4][$];
  logic [2:0] exp_o [4];
  logic [3:0] en_prev = 4'b0;

  // Results from watch_frame
  int          r_blen;
  logic [19:0] r_samp;
  logic        r_done_fall;
  int          r_done_other;
  int          r_high_run;
  int          r_tail_busy;
  int          r_tail_done;

  always #5 sys_clk = ~sys_clk;

  uart_send #(.CLK_FREQ(1_000_000), .UART_BPS(100_000)) u_dut0 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .send_en(send_en[0]), .send_data(send_data[0]),
    .tx_busy(busy[0]), .tx_done(done[0]), .uart_txd(txd[0]));

  uart_send #(.CLK_FREQ(1_000_000), .UART_BPS(100_000), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) u_dut1 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .send_en(send_en[1]), .send_data(send_data[1]),
    .tx_busy(busy[1]), .tx_done(done[1]), .uart_txd(txd[1]));

  uart_send #(.CLK_FREQ(1_000_000), .UART_BPS(100_000), .PARITY_EN(1'b1), .PARITY_ODD(1'b1)) u_dut2 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .send_en(send_en[2]), .send_data(send_data[2]),
    .tx_busy(busy[2]), .tx_done(done[2]), .uart_txd(txd[2]));

  uart_send #(.CLK_FREQ(1_000_000), .UART_BPS(100_000), .STOP_BITS(2)) u_dut3 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .send_en(send_en[3]), .send_data(send_data[3]),
    .tx_busy(busy[3]), .tx_done(done[3]), .uart_txd(txd[3]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      if (errors <= 40) $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  // Expand one accepted request into its per-cycle line/busy/done sequence
  task automatic push_frame(input int d);
    logic fb [$];
    fb.push_back(1'b0);
    for (int i = 0; i < 16; i++) fb.push_back(send_data[d][i]);
    if (cfg_par_en[d] != 0) fb.push_back((^send_data[d]) ^ (cfg_par_odd[d] != 0));
    for (int s = 0; s < cfg_stops[d]; s++) fb.push_back(1'b1);
    foreach (fb[b]) for (int c = 0; c < BPS; c++) mq[d].push_back({fb[b], 2'b10});
    mq[d].push_back(3'b101);
  endtask

  // Model: a request is taken only on a rising edge when no frame is pending
  initial begin
    for (int d = 0; d < 4; d++) exp_o[d] = 3'b100;
    forever begin
      @(posedge sys_clk or posedge sys_rst);
      for (int d = 0; d < 4; d++) begin
        if (sys_rst) begin
          mq[d].delete();
          en_prev[d] = 1'b0;
          exp_o[d]   = 3'b100;
        end else begin
          if (send_en[d] && !en_prev[d] && (mq[d].size() == 0)) push_frame(d);
          en_prev[d] = send_en[d];
          exp_o[d]   = (mq[d].size() > 0) ? mq[d].pop_front() : 3'b100;
        end
      end
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge
  initial begin
    forever begin
      @(negedge sys_clk);
      if (cmp_on && !sys_rst) begin
        for (int d = 0; d < 4; d++) begin
          check($sformatf("cmp_txd%0d", d), 32'(txd[d]), 32'(exp_o[d][2]));
          check($sformatf("cmp_busy%0d", d), 32'(busy[d]), 32'(exp_o[d][1]));
          check($sformatf("cmp_done%0d", d), 32'(done[d]), 32'(exp_o[d][0]));
        end
      end
    end
  end

  // Request one frame on instance d and observe it until tx_busy falls
  task automatic watch_frame(input int d, input logic [15:0] data, input int mode, input int tail);
    int k;
    bit fell;
    bit rst_hit;
    r_blen = 0; r_samp = '0; r_done_fall = 1'b0; r_done_other = 0;
    r_high_run = 0; r_tail_busy = 0; r_tail_done = 0;
    @(negedge sys_clk);
    check("idle_txd", 32'(txd[d]), 32'd1);
    check("idle_busy", 32'(busy[d]), 32'd0);
    send_en[d]   = 1'b1;
    send_data[d] = data;
    @(posedge sys_clk); #1;
    check("start_txd", 32'(txd[d]), 32'd0);
    check("start_busy", 32'(busy[d]), 32'd1);
    k = 0; fell = 1'b0; rst_hit = 1'b0;
    while (!fell && !rst_hit && k < 400) begin
      if (busy[d]) begin
        r_blen++;
        if (k % BPS == BPS / 2) r_samp[k / BPS] = txd[d];
        if (done[d]) r_done_other++;
        r_high_run = txd[d] ? r_high_run + 1 : 0;
        if (k == 3 && (mode & M_HOLD) == 0) send_en[d] = 1'b0;
        if (k == 40 && (mode & M_CHG) != 0) send_data[d] = 16'h0000;
        if (k == 50 && (mode & M_REEDGE) != 0) send_en[d] = 1'b1;
        if (k == 70 && (mode & M_RST) != 0) begin
          sys_rst = 1'b1;
          #1;
          check("rst_async_txd", 32'(txd[d]), 32'd1);
          check("rst_async_busy", 32'(busy[d]), 32'd0);
          check("rst_async_done", 32'(done[d]), 32'd0);
          rst_hit = 1'b1;
        end else begin
          @(posedge sys_clk); #1;
          k++;
        end
      end else begin
        fell = 1'b1;
        r_high_run  = txd[d] ? r_high_run + 1 : 0;
        r_done_fall = done[d];
      end
    end
    if (!fell && !rst_hit) check("frame_timeout", 32'(k), 32'd0);
    if (!rst_hit) begin
      for (int t = 0; t < tail; t++) begin
        @(posedge sys_clk); #1;
        if (busy[d]) r_tail_busy++;
        if (done[d]) r_tail_done++;
      end
    end
  endtask

  initial begin
    for (int d = 0; d < 4; d++) send_data[d] = 16'h0000;
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    #1;
    check("reset_txd", 32'(txd), 32'hF);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_done", 32'(done), 32'h0);
    cmp_on = 1'b1;

    // Basic frame, 16'hA5C3
    watch_frame(0, 16'hA5C3, 0, 5);
    for (int i = 0; i < 18; i++) check($sformatf("basic_bit%0d", i), 32'(r_samp[i]), 32'(exp_basic[i]));
    check("basic_len", 32'(r_blen), 32'd180);
    check("basic_done_fall", 32'(r_done_fall), 32'd1);
    check("basic_done_early", 32'(r_done_other + r_tail_done), 32'd0);

    // Even parity: eight ones -> 0
    watch_frame(1, 16'hA5C3, 0, 5);
    for (int i = 0; i < 17; i++) check($sformatf("pe_bit%0d", i), 32'(r_samp[i]), 32'(exp_basic[i]));
    check("pe_parity", 32'(r_samp[17]), 32'd0);
    check("pe_stop", 32'(r_samp[18]), 32'd1);
    check("pe_len", 32'(r_blen), 32'd190);
    check("pe_done_fall", 32'(r_done_fall), 32'd1);

    // Odd parity -> 1
    watch_frame(2, 16'hA5C3, 0, 5);
    check("po_parity", 32'(r_samp[17]), 32'd1);
    check("po_stop", 32'(r_samp[18]), 32'd1);
    check("po_len", 32'(r_blen), 32'd190);

    // Busy rejection at cycle 50, enable held through the end, data changed mid-frame
    watch_frame(0, 16'hA5C3, M_CHG | M_REEDGE, 40);
    for (int i = 0; i < 18; i++) check($sformatf("iso_bit%0d", i), 32'(r_samp[i]), 32'(exp_basic[i]));
    check("rej_len", 32'(r_blen), 32'd180);
    check("rej_done_fall", 32'(r_done_fall), 32'd1);
    check("held_no_retrigger", 32'(r_tail_busy), 32'd0);
    check("held_single_done", 32'(r_done_other + r_tail_done), 32'd0);
    @(negedge sys_clk);
    send_en[0] = 1'b0;
    repeat (3) @(negedge sys_clk);

    // Back-to-back with two stop bits; last data bit of 16'h25C3 is 0
    watch_frame(3, 16'h25C3, 0, 0);
    check("b2b_len", 32'(r_blen), 32'd190);
    check("b2b_high_run", 32'(r_high_run), 32'd21);
    send_en[3]   = 1'b1;
    send_data[3] = 16'h1234;
    @(posedge sys_clk); #1;
    check("b2b_next_start_txd", 32'(txd[3]), 32'd0);
    check("b2b_next_start_busy", 32'(busy[3]), 32'd1);
    for (int i = 0; i < 400 && busy[3]; i++) begin
      @(posedge sys_clk); #1;
    end
    check("b2b_second_end", 32'(busy[3]), 32'd0);
    send_en[3] = 1'b0;
    repeat (3) @(negedge sys_clk);

    // Reset at cycle 70, then a clean frame
    watch_frame(0, 16'hA5C3, M_RST, 0);
    check("rst_no_done", 32'(r_done_other), 32'd0);
    repeat (2) @(negedge sys_clk);
    sys_rst = 1'b0;
    #1;
    check("rst_rel_txd", 32'(txd[0]), 32'd1);
    check("rst_rel_busy", 32'(busy[0]), 32'd0);
    check("rst_rel_done", 32'(done[0]), 32'd0);
    watch_frame(0, 16'hA5C3, 0, 5);
    for (int i = 0; i < 18; i++) check($sformatf("post_rst_bit%0d", i), 32'(r_samp[i]), 32'(exp_basic[i]));
    check("post_rst_len", 32'(r_blen), 32'd180);
    check("post_rst_done_fall", 32'(r_done_fall), 32'd1);

    repeat (5) @(negedge sys_clk);
    cmp_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
